// File: rtl/branch_predict_unit.sv
// Branch resolve and predict unit.
// Resolves a branch one cycle after it is presented by execute, compares the
// outcome against the prediction fetch used, and drives a registered redirect.
// Keeps a direct-mapped table of 2-bit saturating direction counters (BHT) and
// a tagged target buffer (BTB). Fetch reads both combinationally to form its
// next-PC prediction.

module branch_predict_unit #(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 16,
    parameter logic [1:0] CTR_INIT  = 2'b01,
    parameter int         PERF_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,

    // Fetch-side lookup
    input  logic [XLEN-1:0]   fetch_pc,
    output logic              pred_taken,
    output logic [XLEN-1:0]   pred_target,
    output logic              pred_hit,

    // Execute-side resolve
    input  logic              invalid,
    input  logic [1:0]        branch_condition,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   branch_pc,
    input  logic [XLEN-1:0]   branch_base,
    input  logic [XLEN-1:0]   immediate,
    input  logic              predicted_taken,
    input  logic [XLEN-1:0]   predicted_target,

    // Registered resolve results
    output logic              branch_taken,
    output logic [XLEN-1:0]   branch_addr,
    output logic              mispredict,
    output logic [XLEN-1:0]   redirect_addr,
    output logic [PERF_W-1:0] mispredict_count
);

    // Branch condition encodings shared with the decoder.
    localparam logic [1:0] BRANCH_ALU_ZERO    = 2'b00;
    localparam logic [1:0] BRANCH_ALU_NONZERO = 2'b01;
    localparam logic [1:0] BRANCH_FORCE_FALSE = 2'b10;
    localparam logic [1:0] BRANCH_FORCE_TRUE  = 2'b11;

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int TAG_W = XLEN - IDX_W - 2;

    // ------------------------------------------------------------------
    // Prediction tables
    // ------------------------------------------------------------------
    logic [1:0]       ctr_q        [BHT_DEPTH];
    logic             btb_valid_q  [BHT_DEPTH];
    logic [TAG_W-1:0] btb_tag_q    [BHT_DEPTH];
    logic [XLEN-1:0]  btb_target_q [BHT_DEPTH];

    // ------------------------------------------------------------------
    // Fetch lookup: purely combinational on the current table contents,
    // so an update landing on this edge is seen only from the next cycle.
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] fetch_idx;
    logic [TAG_W-1:0] fetch_tag;
    logic             unused_fetch_lsb;

    assign fetch_idx        = fetch_pc[IDX_W+1:2];
    assign fetch_tag        = fetch_pc[XLEN-1:IDX_W+2];
    assign unused_fetch_lsb = ^fetch_pc[1:0];

    // Hit requires a valid entry whose tag matches; direction needs a hit too.
    always_comb begin
        pred_hit    = btb_valid_q[fetch_idx] && (btb_tag_q[fetch_idx] == fetch_tag);
        pred_taken  = pred_hit && ctr_q[fetch_idx][1];
        pred_target = btb_target_q[fetch_idx];
    end

    // ------------------------------------------------------------------
    // Resolve datapath
    // ------------------------------------------------------------------
    logic              res_taken;
    logic [XLEN-1:0]   res_target;
    logic [XLEN-1:0]   res_fallthru;
    logic              res_mispredict;
    logic [IDX_W-1:0]  res_idx;
    logic [TAG_W-1:0]  res_tag;
    logic              res_is_cond;
    logic              res_is_force_true;

    assign res_target        = branch_base + immediate;
    assign res_fallthru      = branch_pc + XLEN'(4);
    assign res_idx           = branch_pc[IDX_W+1:2];
    assign res_tag           = branch_pc[XLEN-1:IDX_W+2];
    assign res_is_cond       = (branch_condition == BRANCH_ALU_ZERO) ||
                               (branch_condition == BRANCH_ALU_NONZERO);
    assign res_is_force_true = (branch_condition == BRANCH_FORCE_TRUE);

    // Decode the resolved direction from the condition and the ALU result.
    always_comb begin
        res_taken = 1'b0;
        case (branch_condition)
            BRANCH_ALU_ZERO:    res_taken = (alu_result == '0);
            BRANCH_ALU_NONZERO: res_taken = (alu_result != '0);
            BRANCH_FORCE_FALSE: res_taken = 1'b0;
            BRANCH_FORCE_TRUE:  res_taken = 1'b1;
            default:            res_taken = 1'b0;
        endcase
    end

    // A wrong direction, or a right "taken" guess with the wrong target, both redirect.
    always_comb begin
        res_mispredict = (res_taken != predicted_taken) ||
                         (res_taken && predicted_taken && (predicted_target != res_target));
    end

    // ------------------------------------------------------------------
    // Table update control
    // ------------------------------------------------------------------
    logic       ctr_we;
    logic [1:0] ctr_cur;
    logic [1:0] ctr_d;
    logic       btb_we;

    assign ctr_cur = ctr_q[res_idx];

    // Conditional branches train the counter; unconditional jumps pin it to strong taken.
    always_comb begin
        ctr_we = 1'b0;
        ctr_d  = ctr_cur;
        btb_we = 1'b0;
        if (!invalid) begin
            if (res_is_cond) begin
                ctr_we = 1'b1;
                if (res_taken) begin
                    ctr_d  = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
                    btb_we = 1'b1;
                end else begin
                    ctr_d  = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
                end
            end else if (res_is_force_true) begin
                ctr_we = 1'b1;
                ctr_d  = 2'b11;
                btb_we = 1'b1;
            end
        end
    end

    // Table storage; reset clears the BTB and returns every counter to its initial bias.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                ctr_q[i]        <= CTR_INIT;
                btb_valid_q[i]  <= 1'b0;
                btb_tag_q[i]    <= '0;
                btb_target_q[i] <= '0;
            end
        end else begin
            if (ctr_we) begin
                ctr_q[res_idx] <= ctr_d;
            end
            if (btb_we) begin
                // Direct-mapped: an entry with a different tag is simply replaced.
                btb_valid_q[res_idx]  <= 1'b1;
                btb_tag_q[res_idx]    <= res_tag;
                btb_target_q[res_idx] <= res_target;
            end
        end
    end

    // ------------------------------------------------------------------
    // Registered resolve outputs
    // ------------------------------------------------------------------
    logic              branch_taken_q,  branch_taken_d;
    logic [XLEN-1:0]   branch_addr_q,   branch_addr_d;
    logic              mispredict_q,    mispredict_d;
    logic [XLEN-1:0]   redirect_addr_q, redirect_addr_d;
    logic [PERF_W-1:0] count_q,         count_d;

    // Bubbles clear the pulses but leave the address registers holding their last value.
    always_comb begin
        branch_taken_d  = 1'b0;
        mispredict_d    = 1'b0;
        branch_addr_d   = branch_addr_q;
        redirect_addr_d = redirect_addr_q;
        count_d         = count_q;
        if (!invalid) begin
            branch_taken_d  = res_taken;
            mispredict_d    = res_mispredict;
            branch_addr_d   = res_target;
            redirect_addr_d = res_taken ? res_target : res_fallthru;
            if (res_mispredict && (count_q != {PERF_W{1'b1}})) begin
                count_d = count_q + PERF_W'(1);
            end
        end
    end

    // Output registers; an asynchronous reset discards whatever was resolving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_taken_q  <= 1'b0;
            branch_addr_q   <= '0;
            mispredict_q    <= 1'b0;
            redirect_addr_q <= '0;
            count_q         <= '0;
        end else begin
            branch_taken_q  <= branch_taken_d;
            branch_addr_q   <= branch_addr_d;
            mispredict_q    <= mispredict_d;
            redirect_addr_q <= redirect_addr_d;
            count_q         <= count_d;
        end
    end

    assign branch_taken     = branch_taken_q;
    assign branch_addr      = branch_addr_q;
    assign mispredict       = mispredict_q;
    assign redirect_addr    = redirect_addr_q;
    assign mispredict_count = count_q;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Bench for branch_predict_unit: directed scenarios with literal expectations,
// then randomized resolves checked every cycle against a behavioural model.
// A second instance with PERF_W=2 and BHT_DEPTH=4 shares the resolve inputs.

module tb_branch_predict_unit;

    localparam logic [1:0] C_ZERO = 2'b00;
    localparam logic [1:0] C_NZ   = 2'b01;
    localparam logic [1:0] C_FF   = 2'b10;
    localparam logic [1:0] C_FT   = 2'b11;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [31:0] fetch_pc;
    logic        invalid;
    logic [1:0]  branch_condition;
    logic [31:0] alu_result, branch_pc, branch_base, immediate, predicted_target;
    logic        predicted_taken;

    logic        pred_taken, pred_hit, branch_taken, mispredict;
    logic [31:0] pred_target, branch_addr, redirect_addr;
    logic [15:0] mispredict_count;

    logic        p2_pred_taken, p2_pred_hit, p2_branch_taken, p2_mispredict;
    logic [31:0] p2_pred_target, p2_branch_addr, p2_redirect_addr;
    logic [1:0]  p2_count;

    branch_predict_unit dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .pred_taken(pred_taken), .pred_target(pred_target), .pred_hit(pred_hit),
        .invalid(invalid), .branch_condition(branch_condition), .alu_result(alu_result),
        .branch_pc(branch_pc), .branch_base(branch_base), .immediate(immediate),
        .predicted_taken(predicted_taken), .predicted_target(predicted_target),
        .branch_taken(branch_taken), .branch_addr(branch_addr), .mispredict(mispredict),
        .redirect_addr(redirect_addr), .mispredict_count(mispredict_count)
    );

    branch_predict_unit #(.BHT_DEPTH(4), .PERF_W(2)) dut_p2 (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc),
        .pred_taken(p2_pred_taken), .pred_target(p2_pred_target), .pred_hit(p2_pred_hit),
        .invalid(invalid), .branch_condition(branch_condition), .alu_result(alu_result),
        .branch_pc(branch_pc), .branch_base(branch_base), .immediate(immediate),
        .predicted_taken(predicted_taken), .predicted_target(predicted_target),
        .branch_taken(p2_branch_taken), .branch_addr(p2_branch_addr), .mispredict(p2_mispredict),
        .redirect_addr(p2_redirect_addr), .mispredict_count(p2_count)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Counters held as plain integers 0..3, tags as pc>>6 for a 16-entry table.
    int          m_ctr   [16];
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    logic        m_taken = 1'b0, m_misp = 1'b0;
    logic [31:0] m_addr = '0, m_redir = '0;
    int          m_count = 0, m_count2 = 0;
    logic        mt;
    logic [31:0] mtarget;
    int          mi;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                m_ctr[i] = 1; m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0;
            end
            m_taken = 0; m_misp = 0; m_addr = '0; m_redir = '0; m_count = 0; m_count2 = 0;
        end else if (invalid) begin
            m_taken = 0;
            m_misp  = 0;
        end else begin
            case (branch_condition)
                C_ZERO:  mt = (alu_result == 0);
                C_NZ:    mt = (alu_result != 0);
                C_FF:    mt = 0;
                default: mt = 1;
            endcase
            mtarget = branch_base + immediate;
            m_taken = mt;
            m_addr  = mtarget;
            m_redir = mt ? mtarget : branch_pc + 32'd4;
            m_misp  = (mt != predicted_taken) || (mt && predicted_taken && predicted_target != mtarget);
            if (m_misp) begin
                m_count  = (m_count  < 65535) ? m_count + 1  : 65535;
                m_count2 = (m_count2 < 3)     ? m_count2 + 1 : 3;
            end
            mi = int'((branch_pc >> 2) & 32'hF);
            if (branch_condition == C_ZERO || branch_condition == C_NZ)
                m_ctr[mi] = mt ? ((m_ctr[mi] == 3) ? 3 : m_ctr[mi] + 1)
                               : ((m_ctr[mi] == 0) ? 0 : m_ctr[mi] - 1);
            else if (branch_condition == C_FT)
                m_ctr[mi] = 3;
            if (mt && branch_condition != C_FF) begin
                m_valid[mi] = 1; m_tag[mi] = branch_pc >> 6; m_tgt[mi] = mtarget;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int  fi;
    logic f_hit;
    always @(negedge clk) begin
        fi    = int'((fetch_pc >> 2) & 32'hF);
        f_hit = m_valid[fi] && (m_tag[fi] == (fetch_pc >> 6));
        chk("branch_taken",  branch_taken,     m_taken);
        chk("branch_addr",   branch_addr,      m_addr);
        chk("mispredict",    mispredict,       m_misp);
        chk("redirect_addr", redirect_addr,    m_redir);
        chk("count",         mispredict_count, m_count);
        chk("pred_hit",      pred_hit,         f_hit);
        chk("pred_taken",    pred_taken,       f_hit && (m_ctr[fi] >= 2));
        if (f_hit) chk("pred_target", pred_target, m_tgt[fi]);
        chk("p2_mispredict", p2_mispredict,    m_misp);
        chk("p2_count",      p2_count,         m_count2);
    end

    // ---------------- driver tasks ----------------
    task automatic res(input logic inv, input logic [1:0] cond, input logic [31:0] alu,
                       input logic [31:0] pc, input logic [31:0] base, input logic [31:0] imm,
                       input logic pt, input logic [31:0] ptgt);
        invalid = inv; branch_condition = cond; alu_result = alu; branch_pc = pc;
        branch_base = base; immediate = imm; predicted_taken = pt; predicted_target = ptgt;
        @(posedge clk); #2;
        invalid = 1'b1;
    endtask

    task automatic look(input string nm, input logic [31:0] pc, input logic hit,
                        input logic tk, input logic [31:0] tgt);
        fetch_pc = pc;
        #1;
        chk({nm, "_hit"}, pred_hit, hit);
        chk({nm, "_taken"}, pred_taken, tk);
        if (hit) chk({nm, "_target"}, pred_target, tgt);
    endtask

    // ---------------- stimulus ----------------
    int          saved_count;
    logic [31:0] rpc, rbase, rimm;

    initial begin
        rst_n = 1'b0; invalid = 1'b1; branch_condition = C_FF; alu_result = '0;
        branch_pc = '0; branch_base = '0; immediate = '0; predicted_taken = 1'b0;
        predicted_target = '0; fetch_pc = '0;
        repeat (3) @(posedge clk);
        #2;
        // Reset state
        chk("rst_branch_taken", branch_taken, 0);
        chk("rst_mispredict", mispredict, 0);
        chk("rst_branch_addr", branch_addr, 0);
        chk("rst_redirect", redirect_addr, 0);
        chk("rst_count", mispredict_count, 0);
        for (int i = 0; i < 16; i++) look("rst_lookup", 32'h100 + 32'(i * 4), 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // BNE mispredicted not-taken
        res(0, C_NZ, 5, 32'h100, 32'h100, 32'h20, 0, 0);
        chk("bne_taken", branch_taken, 1);
        chk("bne_addr", branch_addr, 32'h120);
        chk("bne_misp", mispredict, 1);
        chk("bne_redirect", redirect_addr, 32'h120);
        look("bne_lookup", 32'h100, 1, 1, 32'h120);
        chk("bne_model_ctr", m_ctr[0], 2);

        // BEQ predicted taken but falls through (same index as 0x100)
        res(0, C_ZERO, 1, 32'h200, 32'h200, 32'h40, 1, 32'h240);
        chk("beq_taken", branch_taken, 0);
        chk("beq_misp", mispredict, 1);
        chk("beq_redirect", redirect_addr, 32'h204);
        chk("beq_model_ctr", m_ctr[0], 1);
        look("beq_lookup", 32'h100, 1, 0, 32'h120);

        // Saturation: 3 taken then 5 not-taken at index 1
        repeat (3) res(0, C_ZERO, 0, 32'h44, 32'h44, 32'h10, 0, 0);
        chk("sat_hi_ctr", m_ctr[1], 3);
        look("sat_hi_lookup", 32'h44, 1, 1, 32'h54);
        repeat (5) res(0, C_ZERO, 7, 32'h44, 32'h44, 32'h10, 1, 32'h54);
        chk("sat_lo_ctr", m_ctr[1], 0);
        look("sat_lo_lookup", 32'h44, 1, 0, 32'h54);

        // Bubble with FORCE_TRUE: nothing changes
        saved_count = m_count;
        res(1, C_FT, 0, 32'h300, 32'h300, 32'h8, 0, 0);
        chk("inv_taken", branch_taken, 0);
        chk("inv_misp", mispredict, 0);
        chk("inv_addr_hold", branch_addr, 32'h54);
        chk("inv_redirect_hold", redirect_addr, 32'h48);
        chk("inv_count", mispredict_count, saved_count);
        look("inv_lookup", 32'h300, 0, 0, 0);

        // Aliasing: 0x144 evicts 0x104 in a 16-entry table
        res(0, C_FT, 0, 32'h104, 32'h104, 32'h100, 0, 0);
        look("alias_first", 32'h104, 1, 1, 32'h204);
        res(0, C_FT, 0, 32'h144, 32'h0, 32'h500, 0, 0);
        look("alias_evicted", 32'h104, 0, 0, 0);
        look("alias_second", 32'h144, 1, 1, 32'h500);
        chk("count_literal", mispredict_count, 12);
        chk("p2_count_sat", p2_count, 3);

        // Randomized resolves with live fetch lookups
        for (int n = 0; n < 3000; n++) begin
            rpc   = 32'h1000 + (32'($urandom_range(0, 31)) << 2);
            rbase = ($urandom_range(0, 9) == 0) ? $urandom : rpc;
            rimm  = ($urandom_range(0, 9) == 0) ? $urandom : (32'($urandom_range(0, 15)) << 2);
            fetch_pc = 32'h1000 + (32'($urandom_range(0, 31)) << 2);
            res(($urandom_range(0, 7) == 0), 2'($urandom_range(0, 3)),
                ($urandom_range(0, 1) == 0) ? 32'h0 : $urandom,
                rpc, rbase, rimm, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 2) == 0) ? rbase + rimm + 32'd4 : rbase + rimm);
        end

        // Reset asserted while a mispredicting resolve is in flight
        invalid = 0; branch_condition = C_FT; branch_pc = 32'h1010; branch_base = 32'h1010;
        immediate = 32'h40; predicted_taken = 0; predicted_target = 0;
        #1 rst_n = 1'b0;
        @(posedge clk); #2;
        invalid = 1'b1;
        chk("mid_rst_taken", branch_taken, 0);
        chk("mid_rst_misp", mispredict, 0);
        chk("mid_rst_redirect", redirect_addr, 0);
        chk("mid_rst_count", mispredict_count, 0);
        look("mid_rst_lookup", 32'h1010, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;
        res(0, C_NZ, 1, 32'h1010, 32'h1010, 32'h40, 1, 32'h1050);
        chk("post_rst_misp", mispredict, 0);
        look("post_rst_lookup", 32'h1010, 1, 1, 32'h1050);
        repeat (2) @(posedge clk);
        #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
